// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through and runs loads/stores as
// byte-serial little-endian transactions on an 8-bit synchronous RAM port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepts the current op; NOPs pass straight through
// BUSY  | byte transfer in progress (cnt = byte index, buf = load bytes)
// DONE  | result presentation; stall released, back to IDLE next edge
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       store_data,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_buf, w_buf_nx;

  logic        w_is_load, w_is_store;
  logic [1:0]  w_last;
  logic        w_xfer, w_wr, w_stall;
  logic [1:0]  w_idx;
  logic [7:0]  w_st_byte;
  logic [31:0] w_ld_result;

  // Opcode decode: class and index of the last byte (N-1).
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_last     = 2'd0;
    case (mem_op)
      OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_last = 2'd0; end
      OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_last = 2'd1; end
      OP_LW:         begin w_is_load  = 1'b1; w_last = 2'd3; end
      OP_SB:         begin w_is_store = 1'b1; w_last = 2'd0; end
      OP_SH:         begin w_is_store = 1'b1; w_last = 2'd1; end
      OP_SW:         begin w_is_store = 1'b1; w_last = 2'd3; end
      default:       ;
    endcase
  end

  // State, byte counter and assembly buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_buf   <= w_buf_nx;
    end
  end

  // Next-state logic plus which byte (if any) is on the bus this cycle.
  // Loads: in BUSY, cnt is the byte being captured from ram_din, and the
  // address of the following byte is presented at the same time.
  // Stores: in BUSY, cnt is the byte being written.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_buf_nx   = r_buf;
    w_xfer     = 1'b0;
    w_wr       = 1'b0;
    w_stall    = 1'b0;
    w_idx      = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_is_load) begin
          w_stall    = 1'b1;
          w_xfer     = 1'b1;
          w_cnt_nx   = 2'd0;
          w_buf_nx   = 32'd0;
          w_state_nx = S_BUSY;
        end else if (w_is_store) begin
          w_stall  = 1'b1;
          w_xfer   = 1'b1;
          w_wr     = 1'b1;
          w_cnt_nx = 2'd1;
          w_state_nx = (w_last == 2'd0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_is_load) begin
          w_buf_nx[{r_cnt, 3'b000} +: 8] = ram_din;
          if (r_cnt == w_last) begin
            w_state_nx = S_DONE;
          end else begin
            w_xfer   = 1'b1;
            w_idx    = r_cnt + 2'd1;
            w_cnt_nx = r_cnt + 2'd1;
          end
        end else if (w_is_store) begin
          w_xfer = 1'b1;
          w_wr   = 1'b1;
          w_idx  = r_cnt;
          if (r_cnt == w_last) w_state_nx = S_DONE;
          else                 w_cnt_nx   = r_cnt + 2'd1;
        end else begin
          // Op vanished mid-transaction (upstream broke the hold contract).
          w_stall    = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 2'd0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 2'd0;
      end
    endcase
  end

  // Store byte selection and load sign/zero extension.
  always_comb begin
    w_st_byte = store_data[{w_idx, 3'b000} +: 8];
    case (mem_op)
      OP_LB:   w_ld_result = {{24{r_buf[7]}}, r_buf[7:0]};
      OP_LH:   w_ld_result = {{16{r_buf[15]}}, r_buf[15:0]};
      OP_LBU:  w_ld_result = {24'd0, r_buf[7:0]};
      OP_LHU:  w_ld_result = {16'd0, r_buf[15:0]};
      default: w_ld_result = r_buf;
    endcase
  end

  // Output drive; everything forced low while reset is held.
  always_comb begin
    waddr_o   = '0;
    we_o      = 1'b0;
    wdata_o   = '0;
    stall_req = 1'b0;
    ram_a     = '0;
    ram_wr    = 1'b0;
    ram_dout  = '0;
    if (!rst) begin
      waddr_o   = waddr_i;
      stall_req = w_stall;
      ram_wr    = w_wr;
      ram_a     = w_xfer ? (mem_addr + ADDR_W'(w_idx)) : mem_addr;
      ram_dout  = w_wr ? w_st_byte : 8'd0;
      if (w_stall) begin
        we_o    = 1'b0;
        wdata_o = '0;
      end else begin
        we_o    = we_i;
        wdata_o = (r_state == S_DONE && w_is_load) ? w_ld_result : wdata_i;
      end
    end
  end

endmodule
